// File: rtl/dt_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// dt_ctrl_pkg
// Shared definitions for the decision-tree dispatch controller:
//   - FSM state encoding (IDLE/LAUNCH/WAIT/RESULT)
//   - result status codes (OK / classifier error / watchdog timeout)
//   - CAN feature field widths and the packed 74-bit feature vector
// -----------------------------------------------------------------------------
package dt_ctrl_pkg;

    // Feature field widths
    localparam int ARB_ID_W = 11;
    localparam int DLC_W    = 4;
    localparam int BYTE_W   = 8;
    localparam int SUM_W    = 11;
    localparam int TDELTA_W = 32;
    localparam int FEAT_W   = ARB_ID_W + DLC_W + 2 * BYTE_W + SUM_W + TDELTA_W;

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t S_IDLE   = 2'd0;
    localparam state_t S_LAUNCH = 2'd1;
    localparam state_t S_WAIT   = 2'd2;
    localparam state_t S_RESULT = 2'd3;

    // Result status codes
    localparam logic [1:0] ST_OK  = 2'b00;
    localparam logic [1:0] ST_ERR = 2'b01;
    localparam logic [1:0] ST_TMO = 2'b10;

    // One queued classification request; arb_id occupies the MSBs
    typedef struct packed {
        logic [ARB_ID_W-1:0] arb_id;
        logic [DLC_W-1:0]    dlc;
        logic [BYTE_W-1:0]   first;
        logic [BYTE_W-1:0]   last;
        logic [SUM_W-1:0]    sum;
        logic [TDELTA_W-1:0] tdelta;
    } feat_t;

endpackage

// File: rtl/dt_dispatch_ctrl_fifo.sv
// -----------------------------------------------------------------------------
// dt_feat_fifo
// Synchronous feature-vector FIFO. Pointers carry one extra wrap bit so that
// "full" (same index, different wrap) is distinct from "empty" (identical).
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   push, din       write request and data (ignored when full)
//   pop             read request (ignored when empty)
//   dout            current head entry, valid while !empty
//   full, empty     occupancy flags
// -----------------------------------------------------------------------------
module dt_feat_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 74
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic             do_push, do_pop;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been written
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_q[AW-1:0]] <= din;
    end

    // Head is read combinationally; the consumer registers it on pop
    assign dout = mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/dt_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// dt_dispatch_ctrl
// Buffers CAN feature vectors, issues them one at a time to the decision-tree
// classifier via a start/done handshake, guards each classification with a
// watchdog and returns tagged results on a valid/ready stream. Keeps
// saturating frame / attack / error counters.
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   in_valid/in_ready, in_*    feature-vector input stream
//   dt_start, dt_*             start pulse and stable feature registers to classifier
//   dt_done, dt_is_attack, dt_final_node, dt_error, dt_tree_depth  classifier reply
//   res_valid/res_ready, res_* result stream (status 00 OK, 01 error, 10 timeout)
//   busy                       FSM active or work queued
//   clr_stats, cnt_*           counter clear and saturating statistics
// -----------------------------------------------------------------------------
module dt_dispatch_ctrl
    import dt_ctrl_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 256,
    parameter int CNT_W       = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    // feature input stream
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [10:0]         in_arb_id,
    input  logic [3:0]          in_dlc,
    input  logic [7:0]          in_first,
    input  logic [7:0]          in_last,
    input  logic [10:0]         in_sum,
    input  logic [31:0]         in_tdelta,
    // classifier interface
    output logic                dt_start,
    output logic [10:0]         dt_arb_id,
    output logic [3:0]          dt_dlc,
    output logic [7:0]          dt_first,
    output logic [7:0]          dt_last,
    output logic [10:0]         dt_sum,
    output logic [31:0]         dt_tdelta,
    input  logic                dt_done,
    input  logic                dt_is_attack,
    input  logic [7:0]          dt_final_node,
    input  logic                dt_error,
    input  logic [7:0]          dt_tree_depth,
    // result stream
    output logic                res_valid,
    input  logic                res_ready,
    output logic [10:0]         res_arb_id,
    output logic                res_attack,
    output logic [7:0]          res_node,
    output logic [7:0]          res_depth,
    output logic [1:0]          res_status,
    // status and statistics
    output logic                busy,
    input  logic                clr_stats,
    output logic [CNT_W-1:0]    cnt_frames,
    output logic [CNT_W-1:0]    cnt_attacks,
    output logic [CNT_W-1:0]    cnt_errors
);
    localparam int WD_W = $clog2(TIMEOUT_CYC);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

    // ---------------------------------------------------------------- FIFO
    feat_t             in_feat;
    logic [FEAT_W-1:0] fifo_dout;
    logic              fifo_full, fifo_empty, fifo_pop;

    assign in_feat  = {in_arb_id, in_dlc, in_first, in_last, in_sum, in_tdelta};
    assign in_ready = ~fifo_full;

    dt_feat_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (FEAT_W)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (in_valid),
        .din   (in_feat),
        .pop   (fifo_pop),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // ---------------------------------------------------------------- FSM
    state_t          state_q, state_d;
    feat_t           feat_q, feat_d;
    logic            start_q, start_d;
    logic [WD_W-1:0] wdog_q, wdog_d;
    logic [10:0]     res_id_q, res_id_d;
    logic            res_attack_q, res_attack_d;
    logic [7:0]      res_node_q, res_node_d;
    logic [7:0]      res_depth_q, res_depth_d;
    logic [1:0]      res_status_q, res_status_d;
    logic            res_hs;

    assign fifo_pop = (state_q == S_IDLE) & ~fifo_empty;
    assign res_hs   = (state_q == S_RESULT) & res_ready;

    always_comb begin
        state_d      = state_q;
        feat_d       = feat_q;
        start_d      = 1'b0;
        wdog_d       = wdog_q;
        res_id_d     = res_id_q;
        res_attack_d = res_attack_q;
        res_node_d   = res_node_q;
        res_depth_d  = res_depth_q;
        res_status_d = res_status_q;
        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) begin
                    feat_d  = feat_t'(fifo_dout);
                    state_d = S_LAUNCH;
                end
            end
            S_LAUNCH: begin
                // start is registered, so the pulse is seen during the first WAIT cycle
                start_d = 1'b1;
                wdog_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                // done takes priority over a watchdog expiring in the same cycle
                if (dt_done) begin
                    res_id_d     = feat_q.arb_id;
                    res_attack_d = dt_is_attack;
                    res_node_d   = dt_final_node;
                    res_depth_d  = dt_tree_depth;
                    res_status_d = dt_error ? ST_ERR : ST_OK;
                    state_d      = S_RESULT;
                end else if (wdog_q == WD_LAST) begin
                    res_id_d     = feat_q.arb_id;
                    res_attack_d = 1'b0;
                    res_node_d   = '0;
                    res_depth_d  = '0;
                    res_status_d = ST_TMO;
                    state_d      = S_RESULT;
                end else begin
                    wdog_d = wdog_q + 1'b1;
                end
            end
            S_RESULT: begin
                if (res_ready) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            feat_q       <= '0;
            start_q      <= 1'b0;
            wdog_q       <= '0;
            res_id_q     <= '0;
            res_attack_q <= 1'b0;
            res_node_q   <= '0;
            res_depth_q  <= '0;
            res_status_q <= ST_OK;
        end else begin
            state_q      <= state_d;
            feat_q       <= feat_d;
            start_q      <= start_d;
            wdog_q       <= wdog_d;
            res_id_q     <= res_id_d;
            res_attack_q <= res_attack_d;
            res_node_q   <= res_node_d;
            res_depth_q  <= res_depth_d;
            res_status_q <= res_status_d;
        end
    end

    assign dt_start   = start_q;
    assign dt_arb_id  = feat_q.arb_id;
    assign dt_dlc     = feat_q.dlc;
    assign dt_first   = feat_q.first;
    assign dt_last    = feat_q.last;
    assign dt_sum     = feat_q.sum;
    assign dt_tdelta  = feat_q.tdelta;

    assign res_valid  = (state_q == S_RESULT);
    assign res_arb_id = res_id_q;
    assign res_attack = res_attack_q;
    assign res_node   = res_node_q;
    assign res_depth  = res_depth_q;
    assign res_status = res_status_q;
    assign busy       = (state_q != S_IDLE) | ~fifo_empty;

    // ---------------------------------------------------------- statistics
    // index 0: frames, 1: clean attacks, 2: error or timeout
    logic [2:0] cnt_inc;
    assign cnt_inc[0] = res_hs;
    assign cnt_inc[1] = res_hs & res_attack_q & (res_status_q == ST_OK);
    assign cnt_inc[2] = res_hs & ((res_status_q == ST_ERR) | (res_status_q == ST_TMO));

    for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
        logic [CNT_W-1:0] cnt_q, cnt_d;

        always_comb begin
            cnt_d = cnt_q;
            if (clr_stats)
                cnt_d = '0;
            else if (cnt_inc[gi] && (cnt_q != {CNT_W{1'b1}}))
                cnt_d = cnt_q + 1'b1;
        end

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) cnt_q <= '0;
            else        cnt_q <= cnt_d;
        end
    end

    assign cnt_frames  = g_cnt[0].cnt_q;
    assign cnt_attacks = g_cnt[1].cnt_q;
    assign cnt_errors  = g_cnt[2].cnt_q;

endmodule

// File: tb/tb_dt_dispatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_dt_dispatch_ctrl
// Directed bench for dt_dispatch_ctrl with a mock classifier and a
// transaction-level reference model (queues of expected launches/results
// plus saturating counter totals) checked on every falling edge.
// -----------------------------------------------------------------------------
module tb_dt_dispatch_ctrl;
    import dt_ctrl_pkg::*;

    localparam int FIFO_DEPTH  = 4;
    localparam int TIMEOUT_CYC = 16;
    localparam int CNT_W       = 2;
    localparam int CNT_MAX     = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [10:0]      in_arb_id;
    logic [3:0]       in_dlc;
    logic [7:0]       in_first, in_last;
    logic [10:0]      in_sum;
    logic [31:0]      in_tdelta;
    logic             dt_start;
    logic [10:0]      dt_arb_id;
    logic [3:0]       dt_dlc;
    logic [7:0]       dt_first, dt_last;
    logic [10:0]      dt_sum;
    logic [31:0]      dt_tdelta;
    logic             dt_done, dt_is_attack, dt_error;
    logic [7:0]       dt_final_node, dt_tree_depth;
    logic             res_valid, res_ready, res_attack;
    logic [10:0]      res_arb_id;
    logic [7:0]       res_node, res_depth;
    logic [1:0]       res_status;
    logic             busy, clr_stats;
    logic [CNT_W-1:0] cnt_frames, cnt_attacks, cnt_errors;

    always #5 clk = ~clk;

    dt_dispatch_ctrl #(
        .FIFO_DEPTH  (FIFO_DEPTH),
        .TIMEOUT_CYC (TIMEOUT_CYC),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .in_arb_id     (in_arb_id),
        .in_dlc        (in_dlc),
        .in_first      (in_first),
        .in_last       (in_last),
        .in_sum        (in_sum),
        .in_tdelta     (in_tdelta),
        .dt_start      (dt_start),
        .dt_arb_id     (dt_arb_id),
        .dt_dlc        (dt_dlc),
        .dt_first      (dt_first),
        .dt_last       (dt_last),
        .dt_sum        (dt_sum),
        .dt_tdelta     (dt_tdelta),
        .dt_done       (dt_done),
        .dt_is_attack  (dt_is_attack),
        .dt_final_node (dt_final_node),
        .dt_error      (dt_error),
        .dt_tree_depth (dt_tree_depth),
        .res_valid     (res_valid),
        .res_ready     (res_ready),
        .res_arb_id    (res_arb_id),
        .res_attack    (res_attack),
        .res_node      (res_node),
        .res_depth     (res_depth),
        .res_status    (res_status),
        .busy          (busy),
        .clr_stats     (clr_stats),
        .cnt_frames    (cnt_frames),
        .cnt_attacks   (cnt_attacks),
        .cnt_errors    (cnt_errors)
    );

    // ------------------------------------------------------------ checking
    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // ------------------------------------------------------- mock classifier
    bit         mock_never  = 1'b0;
    int         mock_lat    = 3;
    logic       mock_attack = 1'b0;
    logic       mock_err    = 1'b0;
    logic [7:0] mock_node   = 8'd0;
    logic [7:0] mock_depth  = 8'd0;
    logic       mock_done;
    int         mock_cnt;
    logic       late_done = 1'b0;

    // done rises mock_lat cycles after the start pulse rises
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mock_done <= 1'b0;
            mock_cnt  <= 0;
        end else begin
            mock_done <= 1'b0;
            if (dt_start && !mock_never) begin
                mock_cnt <= mock_lat - 1;
            end else if (mock_cnt == 1) begin
                mock_done <= 1'b1;
                mock_cnt  <= 0;
            end else if (mock_cnt > 1) begin
                mock_cnt <= mock_cnt - 1;
            end
        end
    end

    assign dt_done       = mock_done | late_done;
    assign dt_is_attack  = mock_attack;
    assign dt_error      = mock_err;
    assign dt_final_node = mock_node;
    assign dt_tree_depth = mock_depth;

    // ------------------------------------------------------ reference model
    typedef struct {
        logic [10:0] id;
        logic        attack;
        logic [7:0]  node;
        logic [7:0]  depth;
        logic [1:0]  status;
    } exp_t;

    exp_t        exp_q[$];
    logic [73:0] launch_q[$];
    int          m_frames  = 0;
    int          m_attacks = 0;
    int          m_errors  = 0;
    int          results_seen = 0;

    function automatic int sat_inc(input int v);
        return (v < CNT_MAX) ? v + 1 : v;
    endfunction

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            launch_q.delete();
            m_frames  = 0;
            m_attacks = 0;
            m_errors  = 0;
        end else begin
            check("cnt_frames",  cnt_frames,  m_frames);
            check("cnt_attacks", cnt_attacks, m_attacks);
            check("cnt_errors",  cnt_errors,  m_errors);

            // launches happen in push order with the pushed features
            if (launch_q.size() == 0) begin
                check("spurious_start", dt_start, 1'b0);
            end else if (dt_start) begin
                check("dt_features", {dt_arb_id, dt_dlc, dt_first, dt_last, dt_sum, dt_tdelta},
                      launch_q[0]);
                void'(launch_q.pop_front());
            end

            if (exp_q.size() == 0) begin
                check("spurious_result", res_valid, 1'b0);
            end else if (res_valid) begin
                check("res_arb_id", res_arb_id, exp_q[0].id);
                check("res_attack", res_attack, exp_q[0].attack);
                check("res_node",   res_node,   exp_q[0].node);
                check("res_depth",  res_depth,  exp_q[0].depth);
                check("res_status", res_status, exp_q[0].status);
                if (res_ready) begin
                    exp_t e;
                    e = exp_q.pop_front();
                    results_seen++;
                    $display("result id=%0d status=%0d attack=%0d node=%0d", e.id, e.status, e.attack, e.node);
                    m_frames = sat_inc(m_frames);
                    if (e.attack && e.status == 2'b00) m_attacks = sat_inc(m_attacks);
                    if (e.status != 2'b00) m_errors = sat_inc(m_errors);
                end
            end
            if (clr_stats) begin
                m_frames  = 0;
                m_attacks = 0;
                m_errors  = 0;
            end

            if (in_valid && in_ready) begin
                exp_t e;
                launch_q.push_back({in_arb_id, in_dlc, in_first, in_last, in_sum, in_tdelta});
                e.id = in_arb_id;
                if (mock_never) begin
                    e.attack = 1'b0; e.node = 8'd0; e.depth = 8'd0; e.status = 2'b10;
                end else begin
                    e.attack = mock_attack; e.node = mock_node; e.depth = mock_depth;
                    e.status = mock_err ? 2'b01 : 2'b00;
                end
                exp_q.push_back(e);
                $display("push id=%0d dlc=%0d sum=%0d", in_arb_id, in_dlc, in_sum);
            end
        end
    end

    // ------------------------------------------------------------- drivers
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push_frame(input logic [10:0] id, input logic [3:0] dlc,
                              input logic [10:0] sum, input int budget, output bit acc);
        in_valid  = 1'b1;
        in_arb_id = id;
        in_dlc    = dlc;
        in_first  = id[7:0] ^ 8'h5A;
        in_last   = id[10:3];
        in_sum    = sum;
        in_tdelta = $urandom;
        acc = 1'b0;
        for (int k = 0; k < budget && !acc; k++) begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
    endtask

    task automatic wait_valid(input int budget, output int cyc);
        cyc = 0;
        do begin
            @(negedge clk);
            cyc++;
        end while (!res_valid && cyc < budget);
        check("res_valid_seen", res_valid, 1'b1);
    endtask

    task automatic wait_results(input int n, input int budget);
        int start = results_seen;
        int k = 0;
        while (results_seen < start + n && k < budget) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("results_drained", results_seen - start, n);
    endtask

    task automatic clear_stats();
        clr_stats = 1'b1;
        step(1);
        clr_stats = 1'b0;
    endtask

    // ------------------------------------------------------------ stimulus
    initial begin
        bit acc;
        int cyc;
        rst_n = 1'b0; in_valid = 1'b0; in_arb_id = '0; in_dlc = '0;
        in_first = '0; in_last = '0; in_sum = '0; in_tdelta = '0;
        res_ready = 1'b1; clr_stats = 1'b0;
        step(3);

        // reset state
        @(negedge clk);
        check("rst_in_ready",  in_ready,   1'b1);
        check("rst_res_valid", res_valid,  1'b0);
        check("rst_dt_start",  dt_start,   1'b0);
        check("rst_busy",      busy,       1'b0);
        check("rst_status",    res_status, 2'b00);
        check("rst_dt_id",     dt_arb_id,  11'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        step(2);

        // single frame: start pulse in the window two edges after the push
        mock_never = 1'b0; mock_lat = 3; mock_attack = 1'b0; mock_err = 1'b0;
        mock_node = 8'd12; mock_depth = 8'd4;
        push_frame(11'd510, 4'd8, 11'd474, 4, acc);
        check("t1_accept", acc, 1'b1);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check("t1_start_window", dt_start, (k == 2) ? 1'b1 : 1'b0);
        end
        wait_valid(20, cyc);
        check("t1_id",     res_arb_id, 11'd510);
        check("t1_node",   res_node,   8'd12);
        check("t1_status", res_status, 2'b00);
        @(posedge clk); #1;
        @(negedge clk);
        check("t1_frames", cnt_frames, 2'd1);
        @(posedge clk); #1;

        // backpressure: 1 in flight + 4 queued, the 6th is refused
        clear_stats();
        res_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            push_frame(11'(100 + i), 4'd4, 11'(200 + i), 1, acc);
            check("t2_accept", acc, 1'b1);
        end
        @(negedge clk);
        check("t2_full", in_ready, 1'b0);
        @(posedge clk); #1;
        push_frame(11'd105, 4'd4, 11'd205, 8, acc);
        check("t2_refused", acc, 1'b0);
        res_ready = 1'b1;
        wait_results(5, 200);
        check("t2_ready_again", in_ready, 1'b1);
        check("t2_frames_sat",  cnt_frames, 2'd3);

        // watchdog timeout; res_valid window is 16 edges after leaving LAUNCH
        clear_stats();
        res_ready = 1'b0;
        mock_never = 1'b1; mock_attack = 1'b1; mock_node = 8'h55; mock_depth = 8'd9;
        push_frame(11'd300, 4'd2, 11'd77, 4, acc);
        wait_valid(40, cyc);
        check("t3_latency", cyc, 19);
        check("t3_status",  res_status, 2'b10);
        check("t3_attack",  res_attack, 1'b0);
        @(posedge clk); #1;
        late_done = 1'b1;
        step(1);
        late_done = 1'b0;
        step(2);
        check("t3_node_held", res_node, 8'd0);
        res_ready = 1'b1;
        wait_results(1, 20);
        late_done = 1'b1;
        step(1);
        late_done = 1'b0;
        step(5);
        check("t3_errors", cnt_errors, 2'd1);
        check("t3_idle",   busy,       1'b0);

        // classifier error, then a clean attack
        clear_stats();
        mock_never = 1'b0; mock_attack = 1'b1; mock_err = 1'b1;
        mock_node = 8'd7; mock_depth = 8'd3;
        push_frame(11'd401, 4'd8, 11'd10, 4, acc);
        wait_valid(30, cyc);
        check("t4_status_err", res_status, 2'b01);
        @(posedge clk); #1;
        mock_err = 1'b0;
        push_frame(11'd402, 4'd8, 11'd11, 4, acc);
        wait_valid(30, cyc);
        check("t4_status_ok", res_status, 2'b00);
        @(posedge clk); #1;
        @(negedge clk);
        check("t4_attacks", cnt_attacks, 2'd1);
        check("t4_errors",  cnt_errors,  2'd1);
        @(posedge clk); #1;

        // saturation, then clear coincident with a handshake
        clear_stats();
        for (int i = 0; i < 5; i++) begin
            push_frame(11'(500 + i), 4'd1, 11'd1, 4, acc);
            wait_results(1, 40);
        end
        check("t5_attacks_sat", cnt_attacks, 2'd3);
        check("t5_errors",      cnt_errors,  2'd0);
        res_ready = 1'b0;
        push_frame(11'd520, 4'd1, 11'd1, 4, acc);
        wait_valid(30, cyc);
        @(posedge clk); #1;
        clr_stats = 1'b1;
        res_ready = 1'b1;
        step(1);
        clr_stats = 1'b0;
        @(negedge clk);
        check("t5_clr_frames",  cnt_frames,  2'd0);
        check("t5_clr_attacks", cnt_attacks, 2'd0);
        check("t5_clr_errors",  cnt_errors,  2'd0);
        @(posedge clk); #1;

        // asynchronous reset while WAITing with two frames queued
        mock_never = 1'b1;
        for (int i = 0; i < 3; i++) begin
            push_frame(11'(601 + i), 4'd3, 11'd3, 1, acc);
            check("t6_accept", acc, 1'b1);
        end
        step(2);
        rst_n = 1'b0;
        #1;
        check("t6_res_valid", res_valid, 1'b0);
        check("t6_in_ready",  in_ready,  1'b1);
        check("t6_busy",      busy,      1'b0);
        step(2);
        rst_n = 1'b1;
        step(40);
        check("t6_busy_after",   busy,       1'b0);
        check("t6_frames_after", cnt_frames, 2'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish, got running, expected done");
        $fatal(1, "global timeout");
    end

endmodule
